// File: rtl/md_if.sv
// Handshake bundle between EX/ID and the multiply/divide scheduler.
// The master is the pipeline side and the slave is the scheduler.
interface md_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        hilo_we;
    logic        hilo_sel;
    logic        id_md_use;
    logic        busy;
    logic        stall_req;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, src_a, src_b, hilo_we, hilo_sel, id_md_use,
        input  busy, stall_req, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, hilo_we, hilo_sel, id_md_use,
        output busy, stall_req, done, hi, lo
    );
endinterface

// File: rtl/md_scheduler.sv
// Multi-cycle mult/div sequencer owning HI/LO for the 5-stage MIPS pipeline.
// The result is computed at start and committed to HI/LO after the latency countdown.
module md_scheduler #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    md_if.slave  md
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state;
    state_t            state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_load;
    logic [31:0]       pend_hi;
    logic [31:0]       pend_lo;
    logic [31:0]       hi_q;
    logic [31:0]       lo_q;
    logic [31:0]       res_hi;
    logic [31:0]       res_lo;
    logic              accept;
    logic              finish;

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] divisor;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic        [31:0] quot_u;
    logic        [31:0] rem_u;
    logic               div_zero;

    assign accept   = (state == IDLE) && md.start;
    assign finish   = (state == RUN) && (cnt == CNT_W'(1));
    assign cnt_load = md.op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

    // Divisor is forced non-zero so the dividers never see /0; the zero case is patched below.
    assign div_zero = (md.src_b == 32'd0);
    assign divisor  = div_zero ? 32'd1 : md.src_b;

    always_comb begin
        prod_s = $signed({{32{md.src_a[31]}}, md.src_a}) * $signed({{32{md.src_b[31]}}, md.src_b});
        prod_u = {32'd0, md.src_a} * {32'd0, md.src_b};
        quot_s = $signed(md.src_a) / $signed(divisor);
        rem_s  = $signed(md.src_a) % $signed(divisor);
        quot_u = md.src_a / divisor;
        rem_u  = md.src_a % divisor;
    end

    always_comb begin
        res_hi = hi_q;
        res_lo = lo_q;
        unique case (md.op)
            2'b00: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            2'b01: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            2'b10: begin
                if (!div_zero) begin
                    res_hi = rem_s;
                    res_lo = quot_s;
                end
            end
            2'b11: begin
                if (!div_zero) begin
                    res_hi = rem_u;
                    res_lo = quot_u;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (md.start) state_nx = RUN;
            RUN:     if (cnt == CNT_W'(1)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        md.busy      = (state == RUN);
        md.done      = finish;
        md.stall_req = md.id_md_use & ((state == RUN) | md.start);
        md.hi        = hi_q;
        md.lo        = lo_q;
    end

    // mthi/mtlo only land when the unit is idle and no op is being accepted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            if (accept) begin
                cnt     <= cnt_load;
                pend_hi <= res_hi;
                pend_lo <= res_lo;
            end else if (state == RUN) begin
                cnt <= cnt - CNT_W'(1);
            end

            if (finish) begin
                hi_q <= pend_hi;
                lo_q <= pend_lo;
            end else if ((state == IDLE) && !md.start && md.hilo_we) begin
                if (md.hilo_sel) begin
                    hi_q <= md.src_a;
                end else begin
                    lo_q <= md.src_a;
                end
            end
        end
    end

endmodule

// File: tb/tb_md_scheduler.sv
// Self-checking bench for md_scheduler: directed literal cases plus a randomized run
// compared every cycle against a behavioural HI/LO model.
module tb_md_scheduler;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    md_if bus();

    md_scheduler #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N),
        .CNT_W      (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .md   (bus)
    );

    int checks = 0;
    int errors = 0;

    int busy_seen = 0;
    int done_seen = 0;
    int stall_seen = 0;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference result as {hi, lo}, computed with 64-bit integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] cur_hi,
                                               input logic [31:0] cur_lo);
        longint          sa = $signed(a);
        longint          sb = $signed(b);
        longint unsigned ua = a;
        longint unsigned ub = b;
        longint          q;
        longint          r;
        longint unsigned uq;
        longint unsigned ur;
        if (op[1] && b == 32'd0) return {cur_hi, cur_lo};
        case (op)
            2'b00: return sa * sb;
            2'b01: return ua * ub;
            2'b10: begin
                q = sa / sb;
                r = sa - q * sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                uq = ua / ub;
                ur = ua - uq * ub;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    logic        model_valid = 1'b0;
    logic [31:0] m_hi, m_lo, m_res_hi, m_res_lo;
    int          m_left;

    always @(posedge clk) begin
        if (reset === 1'b0) begin
            model_valid <= 1'b1;
            m_hi        <= '0;
            m_lo        <= '0;
            m_res_hi    <= '0;
            m_res_lo    <= '0;
            m_left      <= 0;
        end else if (model_valid) begin
            if (m_left > 0) begin
                if (m_left == 1) begin
                    m_hi <= m_res_hi;
                    m_lo <= m_res_lo;
                end
                m_left <= m_left - 1;
            end else if (bus.start) begin
                {m_res_hi, m_res_lo} <= ref_result(bus.op, bus.src_a, bus.src_b, m_hi, m_lo);
                m_left <= bus.op[1] ? DIV_N : MULT_N;
            end else if (bus.hilo_we) begin
                if (bus.hilo_sel) m_hi <= bus.src_a;
                else              m_lo <= bus.src_a;
            end
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check_output("busy", 32'(bus.busy), 32'(m_left > 0));
            check_output("done", 32'(bus.done), 32'(m_left == 1));
            check_output("stall_req", 32'(bus.stall_req), 32'(bus.id_md_use & ((m_left > 0) | bus.start)));
            check_output("hi", bus.hi, m_hi);
            check_output("lo", bus.lo, m_lo);
        end
        busy_seen  <= busy_seen + int'(bus.busy);
        done_seen  <= done_seen + int'(bus.done);
        stall_seen <= stall_seen + int'(bus.stall_req);
    end

    task automatic apply_stimulus(input logic rst, input logic st, input logic [1:0] op,
                                  input logic [31:0] a, input logic [31:0] b, input logic we,
                                  input logic sel, input logic use_md);
        reset         = rst;
        bus.start     = st;
        bus.op        = op;
        bus.src_a     = a;
        bus.src_b     = b;
        bus.hilo_we   = we;
        bus.hilo_sel  = sel;
        bus.id_md_use = use_md;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic use_md);
        for (int i = 0; i < n; i++) apply_stimulus(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, use_md);
    endtask

    task automatic clear_counts();
        @(negedge clk);
        busy_seen  = 0;
        done_seen  = 0;
        stall_seen = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_hilo(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        check_output({name, " dut hi"}, bus.hi, exp_hi);
        check_output({name, " dut lo"}, bus.lo, exp_lo);
        check_output({name, " model hi"}, m_hi, exp_hi);
        check_output({name, " model lo"}, m_lo, exp_lo);
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [31:0] r_a, r_b;

        apply_stimulus(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        check_output("reset busy", 32'(bus.busy), 32'd0);
        check_output("reset stall_req", 32'(bus.stall_req), 32'd0);
        check_output("reset done", 32'(bus.done), 32'd0);
        check_hilo("reset", 32'h0, 32'h0);

        clear_counts();
        apply_stimulus(1'b1, 1'b1, 2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0, 1'b1);
        idle(MULT_N, 1'b1);
        check_hilo("mult -3*7", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        check_output("mult busy cycles", 32'(busy_seen), 32'd5);
        check_output("mult done pulses", 32'(done_seen), 32'd1);
        check_output("mult stall cycles", 32'(stall_seen), 32'd6);
        idle(1, 1'b1);
        check_output("stall after done", 32'(bus.stall_req), 32'd0);

        clear_counts();
        apply_stimulus(1'b1, 1'b1, 2'b11, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
        idle(DIV_N, 1'b0);
        check_hilo("divu 100/7", 32'd2, 32'd14);
        check_output("divu busy cycles", 32'(busy_seen), 32'd10);
        check_output("divu stall with no use", 32'(stall_seen), 32'd0);

        apply_stimulus(1'b1, 1'b1, 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b0);
        idle(DIV_N, 1'b0);
        check_hilo("div -7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        apply_stimulus(1'b1, 1'b0, 2'b00, 32'd5, 32'h0, 1'b1, 1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b0, 2'b00, 32'd9, 32'h0, 1'b1, 1'b0, 1'b0);
        clear_counts();
        apply_stimulus(1'b1, 1'b1, 2'b10, 32'd1234, 32'd0, 1'b0, 1'b0, 1'b0);
        idle(DIV_N, 1'b0);
        check_hilo("div by zero", 32'd5, 32'd9);
        check_output("div0 busy cycles", 32'(busy_seen), 32'd10);
        check_output("div0 done pulses", 32'(done_seen), 32'd1);

        clear_counts();
        apply_stimulus(1'b1, 1'b1, 2'b00, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);
        apply_stimulus(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        check_output("abort busy", 32'(bus.busy), 32'd0);
        check_hilo("abort", 32'h0, 32'h0);
        idle(MULT_N + 2, 1'b0);
        check_output("abort done pulses", 32'(done_seen), 32'd0);
        check_hilo("after abort", 32'h0, 32'h0);

        clear_counts();
        apply_stimulus(1'b1, 1'b1, 2'b00, 32'd6, 32'd7, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 2'b11, 32'd100, 32'd3, 1'b1, 1'b1, 1'b0);
        idle(MULT_N - 1, 1'b0);
        check_hilo("start during run", 32'h0, 32'd42);
        check_output("start during run busy", 32'(busy_seen), 32'd5);
        check_output("start during run done", 32'(done_seen), 32'd1);
        idle(1, 1'b0);
        check_output("idle after run", 32'(bus.busy), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            r_op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       r_a = $urandom_range(0, 20);
                1:       r_a = -($urandom_range(0, 20));
                default: r_a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       r_b = 32'd0;
                1:       r_b = $urandom_range(1, 9);
                2:       r_b = -($urandom_range(1, 9));
                default: r_b = $urandom;
            endcase
            apply_stimulus(($urandom_range(0, 99) != 0), ($urandom_range(0, 4) == 0), r_op, r_a, r_b,
                           ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)));
        end
        idle(DIV_N + 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
